// File: rtl/alu_serial_exec.sv
// Digit-serial ALU for the execute stage: one DIGIT-bit slice per clock, LSB slice first.
// Accepts ADD/SUB/AND/OR/SLT from the ALU decoder and returns the result and a zero flag.
module alu_serial_exec #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inValid,
    output logic             inReady,
    input  logic [2:0]       aluControl,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] aluResult,
    output logic             zero,
    output logic [1:0]       dbgState
);

    // Handshake: a request transfers on a rising edge where inValid & inReady;
    // a result transfers on a rising edge where outValid & outReady. Once raised,
    // outValid and the result stay asserted and stable until that transfer.

    localparam int NSLICE = WIDTH / DIGIT;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    if (WIDTH % DIGIT != 0) begin : g_bad_digit
        $error("alu_serial_exec: WIDTH must be a multiple of DIGIT");
    end

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, stateNext;

    logic [2:0]       opQ;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic [WIDTH-1:0] resQ;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             zeroAcc;
    logic             zeroQ;

    logic             accept;
    logic             lastSlice;
    logic             isSlt;
    logic [DIGIT-1:0] aSl;
    logic [DIGIT-1:0] bSl;
    logic [DIGIT-1:0] bEff;
    logic [DIGIT:0]   sum;
    logic [DIGIT-1:0] sliceRes;
    logic             sliceZero;
    logic             sltBit;
    logic [WIDTH-1:0] resNext;
    logic             zeroNext;

    assign inReady   = rst_n && (state == IDLE);
    assign outValid  = (state == DONE);
    assign aluResult = resQ;
    assign zero      = zeroQ;
    assign dbgState  = state;
    assign accept    = inValid && inReady;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: if (accept) stateNext = CALC;
            CALC: if (lastSlice) stateNext = DONE;
            DONE: if (outReady) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Slice datapath; SUB and SLT share the A + ~B + 1 adder path.
    always_comb begin
        lastSlice = (cnt == LAST);
        isSlt     = (opQ == OP_SLT);
        aSl       = opA[cnt*DIGIT +: DIGIT];
        bSl       = opB[cnt*DIGIT +: DIGIT];
        bEff      = (opQ == OP_SUB || isSlt) ? ~bSl : bSl;
        sum       = {1'b0, aSl} + {1'b0, bEff} + {{DIGIT{1'b0}}, carry};
        case (opQ)
            OP_AND:  sliceRes = aSl & bSl;
            OP_OR:   sliceRes = aSl | bSl;
            default: sliceRes = sum[DIGIT-1:0];
        endcase
        sliceZero = (sliceRes == '0);

        // On the top slice, sliceRes[DIGIT-1] is the sign of A - B.
        sltBit = sliceRes[DIGIT-1] ^
                 ((opA[WIDTH-1] != opB[WIDTH-1]) && (sliceRes[DIGIT-1] != opA[WIDTH-1]));

        resNext = resQ;
        resNext[cnt*DIGIT +: DIGIT] = sliceRes;
        if (isSlt && lastSlice) begin
            resNext = {{(WIDTH-1){1'b0}}, sltBit};
        end
        zeroNext = isSlt ? ~sltBit : (zeroAcc && sliceZero);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opQ     <= OP_ADD;
            opA     <= '0;
            opB     <= '0;
            resQ    <= '0;
            cnt     <= '0;
            carry   <= 1'b0;
            zeroAcc <= 1'b0;
            zeroQ   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        opQ     <= aluControl;
                        opA     <= srcA;
                        opB     <= srcB;
                        cnt     <= '0;
                        carry   <= (aluControl == OP_SUB) || (aluControl == OP_SLT);
                        zeroAcc <= 1'b1;
                    end
                end
                CALC: begin
                    resQ    <= resNext;
                    carry   <= sum[DIGIT];
                    zeroAcc <= zeroAcc && sliceZero;
                    if (lastSlice) begin
                        zeroQ <= zeroNext;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial_exec.sv
// Self-checking bench for alu_serial_exec with a scoreboard queue of expected {zero, result}.
module tb_alu_serial_exec;

    localparam int W      = 32;
    localparam int D      = 8;
    localparam int NSLICE = W / D;

    logic         clk;
    logic         rst_n;
    logic         inValid;
    logic         inReady;
    logic [2:0]   aluControl;
    logic [W-1:0] srcA;
    logic [W-1:0] srcB;
    logic         outValid;
    logic         outReady;
    logic [W-1:0] aluResult;
    logic         zero;
    logic [1:0]   dbgState;

    logic [W:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    alu_serial_exec #(.WIDTH(W), .DIGIT(D)) dut (
        .clk(clk), .rst_n(rst_n),
        .inValid(inValid), .inReady(inReady), .aluControl(aluControl),
        .srcA(srcA), .srcB(srcB),
        .outValid(outValid), .outReady(outReady),
        .aluResult(aluResult), .zero(zero), .dbgState(dbgState)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W:0] model(input logic [2:0] c, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
        logic [W-1:0] r;
        case (c)
            3'b001:  r = a - b;
            3'b010:  r = a & b;
            3'b011:  r = a | b;
            3'b100:  r = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
            default: r = a + b;
        endcase
        return {(r == '0), r};
    endfunction

    task automatic start_op(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                            input bit push);
        int g = 0;
        @(negedge clk);
        while (!inReady && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (!inReady) check("accept_timeout", 0, 1);
        aluControl = c;
        srcA       = a;
        srcB       = b;
        inValid    = 1'b1;
        if (push) exp_q.push_back(model(c, a, b));
        @(posedge clk);
        #1;
        inValid    = 1'b0;
        srcA       = $urandom;
        srcB       = $urandom;
        aluControl = 3'($urandom_range(0, 7));
        check("in_ready_low_in_calc", inReady, 0);
    endtask

    task automatic finish_op(input string tag, input int hold);
        int lat = 0;
        logic [W:0] e;
        while (!outValid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, lat, NSLICE);
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 1, 0);
            e = '0;
        end else begin
            e = exp_q.pop_front();
        end
        check({tag, "_result"}, aluResult, e[W-1:0]);
        check({tag, "_zero"}, zero, e[W]);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, outValid, 1);
            check({tag, "_hold_result"}, aluResult, e[W-1:0]);
            check({tag, "_hold_zero"}, zero, e[W]);
            check({tag, "_hold_in_ready"}, inReady, 0);
            if (i == 2) begin
                inValid    = 1'b1;
                aluControl = 3'b000;
                srcA       = 32'h0000_0011;
                srcB       = 32'h0000_0022;
            end
            if (i == 3) inValid = 1'b0;
        end
        @(negedge clk);
        outReady = 1'b1;
        @(posedge clk);
        #1;
        outReady = 1'b0;
        check({tag, "_release_valid"}, outValid, 0);
        check({tag, "_release_in_ready"}, inReady, 1);
        check({tag, "_release_state"}, dbgState, 0);
        if (hold > 0) begin
            repeat (3) @(posedge clk);
            #1;
            check({tag, "_ignored_req_not_queued"}, {outValid, inReady}, 2'b01);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] c, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int hold);
        start_op(c, a, b, 1'b1);
        finish_op(tag, hold);
    endtask

    initial begin
        rst_n      = 1'b0;
        inValid    = 1'b0;
        outReady   = 1'b0;
        aluControl = 3'b000;
        srcA       = '0;
        srcB       = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", outValid, 0);
        check("rst_in_ready", inReady, 0);
        check("rst_result", aluResult, 0);
        check("rst_zero", zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", inReady, 1);

        run_op("add",        3'b000, 32'h0000_0005, 32'h0000_0003, 0);
        run_op("sub_eq",     3'b001, 32'h1234_5678, 32'h1234_5678, 0);
        run_op("sub_borrow", 3'b001, 32'h0000_0100, 32'h0000_0001, 0);
        run_op("slt_neg",    3'b100, 32'hFFFF_FFFF, 32'h0000_0001, 0);
        run_op("slt_ovf",    3'b100, 32'h7FFF_FFFF, 32'h8000_0000, 0);
        run_op("slt_eq",     3'b100, 32'h0000_0005, 32'h0000_0005, 0);
        run_op("slt_ovf2",   3'b100, 32'h8000_0000, 32'h7FFF_FFFF, 0);
        run_op("and",        3'b010, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0);
        run_op("or",         3'b011, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0);
        run_op("code111",    3'b111, 32'h0000_00FF, 32'h0000_0001, 0);
        run_op("code101",    3'b101, 32'hFFFF_FFFF, 32'h0000_0001, 0);
        run_op("backpress",  3'b000, 32'h1111_1111, 32'h2222_2222, 5);

        for (int k = 0; k < 8; k++) begin
            run_op("rand", 3'($urandom_range(0, 7)), $urandom, $urandom, 0);
        end

        // Abort an ADD after slice 1 has been processed.
        start_op(3'b000, 32'h0000_1000, 32'h0000_2000, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", outValid, 0);
        check("abort_in_ready", inReady, 0);
        check("abort_result", aluResult, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("abort_no_result", outValid, 0);
        run_op("add_after_rst", 3'b000, 32'h0000_0001, 32'h0000_0001, 0);

        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
